// File: rtl/sr_reg_bank.sv
// Bank of independent set/reset channels with a parameterised s=r=1 policy,
// per-channel conflict flags, a sticky error bit and a saturating conflict counter.
module sr_reg_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      MODE      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] conflict,
  output logic             err_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] conflict_q, conflict_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] resolve;
  logic             any_conflict;

  // Value a channel takes when s=r=1; unknown MODE codes fall back to hold.
  always_comb begin
    resolve = q_q;
    case (MODE)
      0:       resolve = '1;
      1:       resolve = '0;
      3:       resolve = ~q_q;
      default: resolve = q_q;
    endcase
  end

  always_comb begin
    q_d          = q_q;
    conflict_d   = '0;
    if (en) begin
      conflict_d = s & r;
      q_d        = (s & ~r) | (q_q & ~s & ~r) | (s & r & resolve);
    end
    any_conflict = |conflict_d;

    err_d = err_q;
    cnt_d = cnt_q;
    if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
    // A conflict on the same edge as a clear counts as the first new event.
    if (any_conflict) begin
      err_d = 1'b1;
      if (err_clr)
        cnt_d = CNT_ONE;
      else if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= RESET_VAL;
      conflict_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign q            = q_q;
  assign conflict     = conflict_q;
  assign err_sticky   = err_q;
  assign conflict_cnt = cnt_q;

endmodule
